mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch and data load/store accesses.
- Arbitrates between the two requesters, sequences each access through issue, wait and response, and returns read data with a one-cycle ready pulse.
- Sits between the fetch/decode stages and the memory block outside the core.

Parameters:
ADDR_W, 32, address width of requester and memory ports
DATA_W, 32, data width of requester and memory ports
MEM_LAT, 1, cycles from mem_en issue to mem_rdata valid; legal range 1..15

Ports:
clk  input  1  main clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request, level; sampled only in IDLE
if_addr  input  ADDR_W  fetch address (PC)
if_ready  output  1  one-cycle pulse: fetch transaction complete
if_rdata  output  DATA_W  registered instruction word
if_err  output  1  pulses with if_ready when if_addr[1:0]!=0
d_req  input  1  data request, level; sampled only in IDLE
d_we  input  1  1=store, 0=load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_ready  output  1  one-cycle pulse: data transaction complete
d_rdata  output  DATA_W  registered load data
d_err  output  1  pulses with d_ready on a misaligned address
mem_en  output  1  one-cycle access strobe to memory
mem_we  output  1  write enable, valid with mem_en
mem_addr  output  ADDR_W  registered address to memory
mem_wdata  output  DATA_W  registered write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous): state=IDLE, last_grant=D, wait counter=0; all outputs 0, including both rdata registers. Reset mid-transaction aborts it: no ready, and any in-flight mem_rdata is discarded.
- FSM states: IDLE, ISSUE, WAIT, RESP. Encode as a case statement.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: round-robin; grant the requester not granted last, so fetch wins first after reset.
  - On a grant: latch gnt_sel, we (forced 0 for fetch), addr and wdata; set last_grant=gnt_sel; next state ISSUE.
- ISSUE (1 cycle):
  - Aligned address: mem_en=1 with registered mem_we/mem_addr/mem_wdata; counter=1; next WAIT.
  - Misaligned address (addr[1:0]!=0): mem_en stays 0, err flag set; next RESP directly.
- WAIT:
  - Lasts exactly MEM_LAT cycles; counter increments each cycle.
  - In the cycle counter==MEM_LAT, the granted rdata register captures mem_rdata on the closing edge, for loads and fetches only. Stores leave rdata unchanged. Next state RESP.
- RESP (1 cycle):
  - Granted ready=1; err=1 if flagged; the other requester's ready stays 0.
  - Next state IDLE.
  - Requests are ignored in RESP. A requester that wants another access keeps req high into the following IDLE cycle; otherwise it drops req at the edge ending RESP.
- Timing: aligned access occupancy is MEM_LAT+3 cycles (IDLE grant → ISSUE → WAIT×MEM_LAT → RESP). Default MEM_LAT=1 gives 4 cycles, with ready in cycle 3 counting the grant cycle as 0. A misaligned access takes 3 cycles.
- Requester inputs are don't-care outside the IDLE grant cycle, because all transaction fields are latched at grant.
- mem_en is 1 only in ISSUE and never in two consecutive cycles. mem_addr/mem_we/mem_wdata hold their values until the next ISSUE.
- rdata outputs hold until overwritten by the next load/fetch to the same requester.
- busy is 0 only in IDLE.

Test Plan:
- Single fetch, MEM_LAT=1: if_req=1, if_addr=0x00000010, memory returns 0xE3A01005 → mem_en in cycle 1 with mem_addr=0x10, mem_we=0; if_ready=1 in cycle 3; if_rdata=0xE3A01005; d_ready stays 0.
- Store then load: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_we=1 and mem_wdata=0xDEADBEEF at issue, d_ready pulses, d_rdata unchanged (0). Then a load from 0x100 returning 0xDEADBEEF → d_rdata=0xDEADBEEF.
- Contention: if_req and d_req both held high from reset → grants alternate I,D,I,D. Each ready pulses once per 4-cycle slot, and neither requester waits more than one slot.
- Misaligned access: d_addr=0x102 → no mem_en; d_ready=1 and d_err=1 in cycle 2; next d_req with d_addr=0x104 completes normally with d_err=0.
- Latency parameter: MEM_LAT=3, fetch 0x20 → exactly 3 WAIT cycles; if_ready in cycle 5; rdata is captured from mem_rdata sampled in the third WAIT cycle, not earlier.
- Reset mid-op: assert reset during WAIT → next cycle busy=0, mem_en=0, both readys 0, rdata registers 0. A fetch issued after reset is granted before a concurrently pending data request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data accesses.
// Round-robin arbitration in IDLE; each access runs ISSUE -> WAIT x MEM_LAT -> RESP.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's fields
// ISSUE | mem_en strobe visible (aligned) or misalignment reported
// WAIT  | count MEM_LAT cycles; capture mem_rdata in the last one
// RESP  | one-cycle ready/err pulse to the granted requester
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic       SEL_I = 1'b0;
    localparam logic       SEL_D = 1'b1;
    localparam logic [3:0] LAT   = 4'(MEM_LAT);

    state_t              state_q;
    logic                gnt_q, last_q, we_q, mis_q;
    logic [3:0]          cnt_q;
    logic                mem_en_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                if_ready_q, if_err_q, d_ready_q, d_err_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;

    logic                gnt_valid_d, gnt_sel_d, req_we_d, mis_d;
    logic [ADDR_W-1:0]   req_addr_d;

    // With both requesting, the side not granted last wins.
    always_comb begin
        gnt_valid_d = if_req | d_req;
        gnt_sel_d   = SEL_I;
        if (if_req && d_req) begin
            gnt_sel_d = (last_q == SEL_D) ? SEL_I : SEL_D;
        end else if (d_req) begin
            gnt_sel_d = SEL_D;
        end
        req_addr_d = (gnt_sel_d == SEL_D) ? d_addr : if_addr;
        req_we_d   = (gnt_sel_d == SEL_D) & d_we;
        mis_d      = |req_addr_d[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= SEL_I;
            last_q      <= SEL_D;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_ready_q   <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid_d) begin
                        gnt_q  <= gnt_sel_d;
                        last_q <= gnt_sel_d;
                        we_q   <= req_we_d;
                        mis_q  <= mis_d;
                        // Strobe registered here so it is visible during ISSUE.
                        if (!mis_d) begin
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= req_we_d;
                            mem_addr_q  <= req_addr_d;
                            mem_wdata_q <= d_wdata;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mis_q) begin
                        if (gnt_q == SEL_I) begin
                            if_ready_q <= 1'b1;
                            if_err_q   <= 1'b1;
                        end else begin
                            d_ready_q <= 1'b1;
                            d_err_q   <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= 4'd1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == LAT) begin
                        if (gnt_q == SEL_I) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end else begin
                            d_ready_q <= 1'b1;
                            if (!we_q) d_rdata_q <= mem_rdata;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    if_ready_q <= 1'b0;
                    if_err_q   <= 1'b0;
                    d_ready_q  <= 1'b0;
                    d_err_q    <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ready  = if_ready_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=1 instance for the main flows,
// MEM_LAT=3 instance for the latency case; negedge memory models and monitors.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ready, if_err, d_ready, d_err, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    logic        l3_if_req, l3_d_req, l3_d_we;
    logic [31:0] l3_if_addr, l3_d_addr, l3_d_wdata, l3_mem_rdata;
    logic        l3_if_ready, l3_if_err, l3_d_ready, l3_d_err, l3_mem_en, l3_mem_we, l3_busy;
    logic [31:0] l3_if_rdata, l3_d_rdata, l3_mem_addr, l3_mem_wdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ready(l3_if_ready), .if_rdata(l3_if_rdata), .if_err(l3_if_err),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_ready(l3_d_ready), .d_rdata(l3_d_rdata), .d_err(l3_d_err),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
        .mem_rdata(l3_mem_rdata), .busy(l3_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_if;
        bit          err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb1[$];
    exp_t sb3[$];

    // Memory models: data valid only in the cycle MEM_LAT after the strobe.
    logic [31:0] mem [256];
    bit          pend1, pend3;
    int          since1, since3;
    logic [7:0]  midx1;

    always @(negedge clk) begin
        if (reset) begin
            pend1 = 0; since1 = 0; mem_rdata = 32'hBAD0_0000;
        end else if (mem_en) begin
            pend1 = 1; since1 = 0; midx1 = mem_addr[9:2];
            if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
            mem_rdata = 32'hBAD0_0000;
        end else begin
            if (pend1) since1++;
            mem_rdata = (pend1 && since1 == 1) ? mem[midx1] : (32'hBAD0_0000 | 32'(since1));
            if (since1 >= 1) pend1 = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            pend3 = 0; since3 = 0; l3_mem_rdata = 32'hBAD1_0000;
        end else if (l3_mem_en) begin
            pend3 = 1; since3 = 0; l3_mem_rdata = 32'hBAD1_0000;
        end else begin
            if (pend3) since3++;
            l3_mem_rdata = (pend3 && since3 == 3) ? 32'hC0DE_0020 : (32'hBAD1_0000 | 32'(since3));
            if (since3 >= 3) pend3 = 0;
        end
    end

    // Monitors: pop the next expected completion whenever a ready appears.
    bit prev_en1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (mem_en) chk("mem_en_back_to_back", 32'(prev_en1), 32'd0);
        prev_en1 = mem_en;
        if ((if_err && !if_ready) || (d_err && !d_ready)) chk("err_without_ready", 32'd1, 32'd0);
        if (if_ready || d_ready) begin
            if (if_ready && d_ready) chk("both_ready", 32'd1, 32'd0);
            if (sb1.size() == 0) begin
                chk("unexpected_ready", 32'(sb1.size()), 32'd1);
            end else begin
                e = sb1.pop_front();
                chk("ready_port_is_if", 32'(if_ready), 32'(e.is_if));
                chk("resp_err", 32'(e.is_if ? if_err : d_err), 32'(e.err));
                chk("resp_rdata", e.is_if ? if_rdata : d_rdata, e.rdata);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (l3_if_ready || l3_d_ready) begin
            if (sb3.size() == 0) begin
                chk("l3_unexpected_ready", 32'(sb3.size()), 32'd1);
            end else begin
                e = sb3.pop_front();
                chk("l3_ready_port_is_if", 32'(l3_if_ready), 32'(e.is_if));
                chk("l3_resp_err", 32'(e.is_if ? l3_if_err : l3_d_err), 32'(e.err));
                chk("l3_resp_rdata", e.is_if ? l3_if_rdata : l3_d_rdata, e.rdata);
            end
        end
    end

    // One transaction on the MEM_LAT=1 instance; returns in its RESP cycle.
    task automatic xact(input bit is_if, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input bit exp_err, input int exp_cyc);
        int cyc;
        @(posedge clk); #1;
        if (is_if) begin
            if_req = 1; if_addr = addr; d_we = 1;
        end else begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        sb1.push_back('{is_if, exp_err, exp_rd});
        @(posedge clk); #1;
        if_req = 0; d_req = 0; if_addr = '1; d_addr = '1; d_wdata = 32'h5555_AAAA;
        chk("issue_mem_en", 32'(mem_en), 32'(!exp_err));
        if (!exp_err) begin
            chk("issue_mem_addr", mem_addr, addr);
            chk("issue_mem_we", 32'(mem_we), 32'(we));
            if (we) chk("issue_mem_wdata", mem_wdata, wdata);
        end
        cyc = 1;
        while (!(is_if ? if_ready : d_ready) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ready_cycle", 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_i, n_d, rdy_cyc, en_cnt;
        bit  seen_d;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hE3A0_1005;
        mem[8'h41] = 32'h0BAD_F00D;
        reset = 1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        l3_if_req = 0; l3_if_addr = 0; l3_d_req = 0; l3_d_we = 0; l3_d_addr = 0; l3_d_wdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_err", 32'({if_err, d_err}), 32'd0);

        xact(1, 0, 32'h0000_0010, 32'h0, 32'hE3A0_1005, 0, 3);
        xact(0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 3);
        xact(0, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 3);
        xact(0, 0, 32'h0000_0102, 32'h0, 32'hDEAD_BEEF, 1, 2);
        xact(0, 0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 0, 3);
        xact(1, 0, 32'h0000_0013, 32'h0, 32'hE3A0_1005, 1, 2);
        chk("if_rdata_hold", if_rdata, 32'hE3A0_1005);

        // Contention from reset: I, D, I, D in 4-cycle slots.
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        if_req = 1; d_req = 1; if_addr = 32'h10; d_addr = 32'h104; d_we = 0;
        sb1.push_back('{1'b1, 1'b0, 32'hE3A0_1005});
        sb1.push_back('{1'b0, 1'b0, 32'h0BAD_F00D});
        sb1.push_back('{1'b1, 1'b0, 32'hE3A0_1005});
        sb1.push_back('{1'b0, 1'b0, 32'h0BAD_F00D});
        n_i = 0; n_d = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 15) begin if_req = 0; d_req = 0; end
            if (if_ready) n_i++;
            if (d_ready) n_d++;
            if (c % 4 == 3) chk("cont_slot_ready", 32'(if_ready | d_ready), 32'd1);
            @(posedge clk); #1;
        end
        chk("cont_if_count", 32'(n_i), 32'd2);
        chk("cont_d_count", 32'(n_d), 32'd2);

        // Reset in WAIT aborts the fetch; afterwards fetch beats a pending load.
        if_req = 1; if_addr = 32'h10;
        @(posedge clk); #1 if_req = 0;
        @(posedge clk); #1;
        reset = 1;
        if_req = 1; d_req = 1; if_addr = 32'h10; d_addr = 32'h104; d_we = 0;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_readys", 32'({if_ready, d_ready}), 32'd0);
        chk("midrst_if_rdata", if_rdata, 32'd0);
        chk("midrst_d_rdata", d_rdata, 32'd0);
        reset = 0;
        sb1.push_back('{1'b1, 1'b0, 32'hE3A0_1005});
        sb1.push_back('{1'b0, 1'b0, 32'h0BAD_F00D});
        seen_d = 0;
        for (int c = 0; c < 12 && !seen_d; c++) begin
            if (if_ready) if_req = 0;
            if (c == 5) d_req = 0;
            if (d_ready) begin
                seen_d = 1;
                chk("post_reset_d_cycle", 32'(c), 32'd7);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("post_reset_d_done", 32'(seen_d), 32'd1);

        // MEM_LAT=3 fetch: three WAIT cycles, capture only in the last one.
        @(posedge clk); #1;
        l3_if_req = 1; l3_if_addr = 32'h20;
        sb3.push_back('{1'b1, 1'b0, 32'hC0DE_0020});
        rdy_cyc = -1; en_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) begin l3_if_req = 0; l3_if_addr = '1; end
            if (l3_mem_en) begin
                en_cnt++;
                chk("l3_en_cycle", 32'(c), 32'd1);
            end
            if (l3_if_ready && rdy_cyc < 0) rdy_cyc = c;
            @(posedge clk); #1;
        end
        chk("l3_ready_cycle", 32'(rdy_cyc), 32'd5);
        chk("l3_en_count", 32'(en_cnt), 32'd1);
        chk("l3_mem_addr", l3_mem_addr, 32'h20);
        chk("l3_mem_we", 32'(l3_mem_we), 32'd0);
        chk("l3_mem_wdata", l3_mem_wdata, 32'd0);
        chk("l3_d_rdata", l3_d_rdata, 32'd0);
        chk("l3_busy_idle", 32'(l3_busy), 32'd0);
        chk("l3_if_rdata_hold", l3_if_rdata, 32'hC0DE_0020);

        repeat (3) @(posedge clk);
        #1;
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        chk("sb3_drained", 32'(sb3.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
